ip4_rtl_rfm_wbq: RTL and testbench
==================================

Name: ip4_rtl_rfm_wbq

Overview:
Register-file-side writeback receiver for the stream processor array's per-FU result stream (spa2rfm.fu[]).
- Accepts up to NUM_FU vector writebacks per cycle.
- Steers each one to a per-bank queue by destination bank.
- Drains each bank at one write per cycle into the banked vector register file.
- Raises registered backpressure to the SPA pipeline when any bank queue nears full.
- Handles per-thread flush on exception.

Parameters:
NUM_FU, 3, functional units presenting writebacks per cycle
NUM_SP, 8, scalar lanes per vector write
NUM_BK, 4, register file banks (one write port each)
WORD_BITS, 32, lane data width
ADR_BITS, 6, register address within a bank/group
GRP_BITS, 2, register group select
TID_BITS, 3, thread id width
QDEPTH, 6, entries per bank queue (must be >= NUM_FU+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset
wb_en  in  NUM_FU  writeback valid per FU
wb_bk  in  NUM_FU*clog2(NUM_BK)  destination bank
wb_grp  in  NUM_FU*GRP_BITS  destination group
wb_adr  in  NUM_FU*ADR_BITS  destination address
wb_tid  in  NUM_FU*TID_BITS  owning thread
wb_msk  in  NUM_FU*NUM_SP  per-lane write enable (SPU exec mask)
wb_data  in  NUM_FU*NUM_SP*WORD_BITS  lane results
flush_en  in  1  kill pending writes of flush_tid
flush_tid  in  TID_BITS  thread to flush
wb_stall  out  1  registered backpressure to SPA
rf_we  out  NUM_BK  bank write strobe
rf_grp  out  NUM_BK*GRP_BITS  write group
rf_adr  out  NUM_BK*ADR_BITS  write address
rf_msk  out  NUM_BK*NUM_SP  lane write mask
rf_data  out  NUM_BK*NUM_SP*WORD_BITS  write data
ovf_err  out  1  sticky: request arrived while stalled and was dropped

Behaviour:
- Reset: one clock (clk); reset rst_n is synchronous, active-low.
  - All queues are emptied.
  - Every output is 0: rf_we, rf_grp, rf_adr, rf_msk, rf_data, wb_stall, ovf_err.
  - Reset mid-operation discards all queued writes; none reach the RF.
- Enqueue:
  - A request with wb_en[f]=1 and wb_msk[f]!=0 is pushed to queue wb_bk[f].
  - A request with all-zero mask is discarded silently.
  - Multiple FUs targeting the same bank in one cycle are pushed in ascending FU index (FU0 first).
  - Order is preserved per bank, so same-address writes land in issue order.
- Drain:
  - Each non-empty bank pops its head once per cycle into a registered rf_* output.
  - A push in cycle N is visible on rf_we at N+1 at the earliest (latency 1). No combinational input-to-output path.
  - rf_we[b]=1 only for a popped entry with nonzero mask. Otherwise rf_we[b]=0 and the other rf_* fields of that bank hold their previous value.
- Occupancy and backpressure:
  - Occupancy is computed after that cycle's pops and pushes. Pop and push in the same cycle are legal, including at full.
  - wb_stall is registered: set next cycle if any bank occupancy > QDEPTH-NUM_FU, cleared otherwise.
  - Default: stall when any bank holds >=4 entries.
- Overflow protocol:
  - SPA must hold wb_en=0 while wb_stall=1.
  - A violation drops the whole request (that FU only) and sets ovf_err, which stays set until reset.
  - A push that would exceed QDEPTH is likewise dropped with ovf_err set.
- Flush:
  - With flush_en=1, every queued entry whose tid==flush_tid has its mask cleared in that cycle.
  - Same-cycle incoming requests with that tid are discarded.
  - The current cycle's pop is also suppressed if its tid matches.
  - Cleared entries still occupy one drain slot each; they pop with rf_we=0 and no compaction is done.
- Flush of a tid with nothing pending has no effect.
- Queue pointers wrap modulo QDEPTH. QDEPTH need not be a power of 2; use explicit wrap compare.

Decomposition:
- ip4_rtl_pkg gets:
  - typedef wbq_ent_s {grp, adr, tid, msk[NUM_SP], data[NUM_SP]}
  - constant WBQ_DEPTH
  - a function for the stall threshold
- One sub-module ip4_rtl_wbq_fifo is natural, instantiated per bank with a generate loop. It is a multi-push (up to NUM_FU), single-pop circular queue with a tid-match mask-clear input.
- Top level holds steering, the stall register and ovf_err.

Test Plan:
- Single write: FU1 bk=2 adr=5 msk=0xFF data=lane i -> cycle+1 rf_we=4'b0100, rf_adr[2]=5, rf_data lanes 0..7, all other banks rf_we=0.
- Bank conflict: FU0,1,2 all bk=0 adr=1,2,3 same cycle -> rf_we[0] on three consecutive cycles with adr 1,2,3; wb_stall stays 0 (occupancy 3).
- Backpressure: 2 consecutive cycles of 3 writes to bk=3 -> occupancy 5 after cycle 2, wb_stall=1 next cycle; it clears once occupancy <=3. Push while stalled -> dropped, ovf_err=1.
- Flush: queue bk=1 with tid 2,5,2, then flush_en tid=2 -> only the tid 5 entry asserts rf_we; three drain cycles elapse. A same-cycle incoming tid 2 request is not written.
- Zero mask and partial mask: msk=0 -> no rf_we ever; msk=0x81 -> rf_msk=0x81.
- Reset mid-stream: assert rst_n=0 with 4 entries queued -> next cycle all outputs 0; after release, no stale writes appear.

Source files
------------

// File: rtl/ip4_rtl_rfm_wbq_pkg.sv
// Shared sizing, queue entry layout and small helpers for the RF-side
// writeback queue.
package ip4_rtl_rfm_wbq_pkg;

    localparam int NUM_FU    = 3;
    localparam int NUM_SP    = 8;
    localparam int NUM_BK    = 4;
    localparam int WORD_BITS = 32;
    localparam int ADR_BITS  = 6;
    localparam int GRP_BITS  = 2;
    localparam int TID_BITS  = 3;
    localparam int QDEPTH    = 6;

    localparam int BK_BITS   = $clog2(NUM_BK);
    localparam int WBQ_DEPTH = QDEPTH;
    localparam int PTR_W     = $clog2(WBQ_DEPTH);
    localparam int CNT_W     = $clog2(WBQ_DEPTH + 1);

    // One queued vector write; data lane 0 sits in the low bits.
    typedef struct packed {
        logic [GRP_BITS-1:0]                grp;
        logic [ADR_BITS-1:0]                adr;
        logic [TID_BITS-1:0]                tid;
        logic [NUM_SP-1:0]                  msk;
        logic [NUM_SP-1:0][WORD_BITS-1:0]   data;
    } wbq_ent_s;

    // Occupancy above this leaves too little room for one full cycle of
    // writebacks from every FU, so the SPA must be held off.
    function automatic logic [CNT_W-1:0] wbq_stall_thr();
        return CNT_W'(WBQ_DEPTH - NUM_FU);
    endfunction

    // Pointer advance with an explicit wrap, since the depth need not be a
    // power of two. inc never exceeds the depth, so one subtract suffices.
    function automatic logic [PTR_W-1:0] wbq_ptr_add(input logic [PTR_W-1:0] ptr,
                                                    input logic [CNT_W-1:0] inc);
        logic [PTR_W:0] sum;
        sum = (PTR_W+1)'(ptr) + (PTR_W+1)'(inc);
        if (sum >= (PTR_W+1)'(WBQ_DEPTH)) begin
            sum = sum - (PTR_W+1)'(WBQ_DEPTH);
        end
        return sum[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/ip4_rtl_rfm_wbq_if.sv
// SPA -> RF writeback bus.
// Handshake: wb_en[f] is the valid for FU f; !wb_stall is a single shared
// ready. A request transfers on any clock where wb_en[f]=1 and wb_stall=0.
// wb_stall is registered, so the SPA sees it one cycle after the queue fills
// and must keep wb_en low while it is high; requests presented anyway are
// dropped and flagged. flush_en/flush_tid are unconditional side-band controls.
interface ip4_rtl_rfm_wbq_if;
    import ip4_rtl_rfm_wbq_pkg::*;

    logic [NUM_FU-1:0]                  wb_en;
    logic [NUM_FU*BK_BITS-1:0]          wb_bk;
    logic [NUM_FU*GRP_BITS-1:0]         wb_grp;
    logic [NUM_FU*ADR_BITS-1:0]         wb_adr;
    logic [NUM_FU*TID_BITS-1:0]         wb_tid;
    logic [NUM_FU*NUM_SP-1:0]           wb_msk;
    logic [NUM_FU*NUM_SP*WORD_BITS-1:0] wb_data;
    logic                               flush_en;
    logic [TID_BITS-1:0]                flush_tid;
    logic                               wb_stall;

    modport master (
        output wb_en, wb_bk, wb_grp, wb_adr, wb_tid, wb_msk, wb_data,
        output flush_en, flush_tid,
        input  wb_stall
    );

    modport slave (
        input  wb_en, wb_bk, wb_grp, wb_adr, wb_tid, wb_msk, wb_data,
        input  flush_en, flush_tid,
        output wb_stall
    );

endinterface

// File: rtl/ip4_rtl_rfm_wbq_fifo.sv
// Per-bank circular queue: up to NUM_FU pushes and one pop per clock, with a
// thread-flush that clears the lane mask of matching entries in place.
module ip4_rtl_rfm_wbq_fifo
    import ip4_rtl_rfm_wbq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_FU-1:0]   push_en,
    input  wbq_ent_s            push_ent [NUM_FU],
    input  logic                flush_en,
    input  logic [TID_BITS-1:0] flush_tid,
    output logic                pop_we,
    output wbq_ent_s            pop_ent,
    output logic [CNT_W-1:0]    occ_nxt,
    output logic                push_drop
);

    wbq_ent_s          mem [WBQ_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  free;
    logic [CNT_W-1:0]  n_acc;
    logic              do_pop;
    logic [NUM_FU-1:0] acc;
    logic [PTR_W-1:0]  slot [NUM_FU];

    // Pop the head when non-empty, then admit pushes in FU order into the
    // space left after that pop; anything beyond that is dropped.
    always_comb begin
        do_pop    = (cnt != '0);
        free      = CNT_W'(WBQ_DEPTH) - cnt + CNT_W'(do_pop);
        n_acc     = '0;
        acc       = '0;
        push_drop = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            slot[f] = wbq_ptr_add(wr_ptr, n_acc);
            if (push_en[f]) begin
                if (n_acc < free) begin
                    acc[f] = 1'b1;
                    n_acc  = n_acc + CNT_W'(1);
                end else begin
                    push_drop = 1'b1;
                end
            end
        end
        occ_nxt = cnt - CNT_W'(do_pop) + n_acc;
    end

    // The head is written out only if it still has lanes to write and is not
    // being flushed this very cycle.
    always_comb begin
        pop_ent = mem[rd_ptr];
        pop_we  = do_pop && (pop_ent.msk != '0) &&
                  !(flush_en && (pop_ent.tid == flush_tid));
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= wbq_ptr_add(rd_ptr, CNT_W'(1));
            end
            wr_ptr <= wbq_ptr_add(wr_ptr, n_acc);
            cnt    <= occ_nxt;
        end
    end

    // Storage: flush clears masks in place (entries keep their drain slot),
    // then accepted pushes land; pushes of a flushed tid never get here.
    always_ff @(posedge clk) begin
        if (flush_en) begin
            for (int i = 0; i < WBQ_DEPTH; i++) begin
                if (mem[i].tid == flush_tid) begin
                    mem[i].msk <= '0;
                end
            end
        end
        for (int f = 0; f < NUM_FU; f++) begin
            if (acc[f]) begin
                mem[slot[f]] <= push_ent[f];
            end
        end
    end

endmodule

// File: rtl/ip4_rtl_rfm_wbq.sv
// RF-side writeback receiver: steers per-FU writebacks into per-bank queues,
// drains one write per bank per clock, and drives registered backpressure.
module ip4_rtl_rfm_wbq
    import ip4_rtl_rfm_wbq_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    ip4_rtl_rfm_wbq_if.slave                   spa,
    output logic [NUM_BK-1:0]                  rf_we,
    output logic [NUM_BK*GRP_BITS-1:0]         rf_grp,
    output logic [NUM_BK*ADR_BITS-1:0]         rf_adr,
    output logic [NUM_BK*NUM_SP-1:0]           rf_msk,
    output logic [NUM_BK*NUM_SP*WORD_BITS-1:0] rf_data,
    output logic                               ovf_err
);

    wbq_ent_s          req_ent  [NUM_FU];
    logic [NUM_FU-1:0] req_ok;
    logic [NUM_FU-1:0] viol;
    logic [NUM_FU-1:0] bk_push  [NUM_BK];
    wbq_ent_s          pop_ent  [NUM_BK];
    logic [CNT_W-1:0]  occ_nxt  [NUM_BK];
    logic [NUM_BK-1:0] pop_we;
    logic [NUM_BK-1:0] bk_drop;
    logic [NUM_BK-1:0] near_full;

    // Unpack each FU's request and decide whether it may enter a queue.
    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            req_ent[f].grp  = spa.wb_grp[f*GRP_BITS +: GRP_BITS];
            req_ent[f].adr  = spa.wb_adr[f*ADR_BITS +: ADR_BITS];
            req_ent[f].tid  = spa.wb_tid[f*TID_BITS +: TID_BITS];
            req_ent[f].msk  = spa.wb_msk[f*NUM_SP +: NUM_SP];
            req_ent[f].data = spa.wb_data[f*NUM_SP*WORD_BITS +: NUM_SP*WORD_BITS];
            viol[f]   = spa.wb_en[f] && spa.wb_stall;
            req_ok[f] = spa.wb_en[f] && !spa.wb_stall && (req_ent[f].msk != '0) &&
                        !(spa.flush_en && (req_ent[f].tid == spa.flush_tid));
        end
    end

    // Route accepted requests to their destination bank.
    always_comb begin
        for (int b = 0; b < NUM_BK; b++) begin
            for (int f = 0; f < NUM_FU; f++) begin
                bk_push[b][f] = req_ok[f] &&
                                (spa.wb_bk[f*BK_BITS +: BK_BITS] == BK_BITS'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BK; b++) begin : g_bank
        ip4_rtl_rfm_wbq_fifo u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push_en   (bk_push[b]),
            .push_ent  (req_ent),
            .flush_en  (spa.flush_en),
            .flush_tid (spa.flush_tid),
            .pop_we    (pop_we[b]),
            .pop_ent   (pop_ent[b]),
            .occ_nxt   (occ_nxt[b]),
            .push_drop (bk_drop[b])
        );
    end

    // Any bank above the threshold after this cycle's traffic stalls the SPA.
    always_comb begin
        for (int b = 0; b < NUM_BK; b++) begin
            near_full[b] = occ_nxt[b] > wbq_stall_thr();
        end
    end

    // Register-file write port registers; fields hold when nothing is written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we   <= '0;
            rf_grp  <= '0;
            rf_adr  <= '0;
            rf_msk  <= '0;
            rf_data <= '0;
        end else begin
            for (int b = 0; b < NUM_BK; b++) begin
                rf_we[b] <= pop_we[b];
                if (pop_we[b]) begin
                    rf_grp[b*GRP_BITS +: GRP_BITS]                 <= pop_ent[b].grp;
                    rf_adr[b*ADR_BITS +: ADR_BITS]                 <= pop_ent[b].adr;
                    rf_msk[b*NUM_SP +: NUM_SP]                     <= pop_ent[b].msk;
                    rf_data[b*NUM_SP*WORD_BITS +: NUM_SP*WORD_BITS] <= pop_ent[b].data;
                end
            end
        end
    end

    // Backpressure register and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spa.wb_stall <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            spa.wb_stall <= |near_full;
            ovf_err      <= ovf_err | (|viol) | (|bk_drop);
        end
    end

endmodule

// File: tb/tb_ip4_rtl_rfm_wbq.sv
// Directed bench for the RF-side writeback queue.
module tb_ip4_rtl_rfm_wbq;
    import ip4_rtl_rfm_wbq_pkg::*;

    localparam int LW = NUM_SP * WORD_BITS;

    logic clk;
    logic rst_n;
    logic [NUM_BK-1:0]                  rf_we;
    logic [NUM_BK*GRP_BITS-1:0]         rf_grp;
    logic [NUM_BK*ADR_BITS-1:0]         rf_adr;
    logic [NUM_BK*NUM_SP-1:0]           rf_msk;
    logic [NUM_BK*NUM_SP*WORD_BITS-1:0] rf_data;
    logic                               ovf_err;

    int total = 0;
    int bad   = 0;
    logic [ADR_BITS-1:0] exp_q[$];

    ip4_rtl_rfm_wbq_if spa_if ();

    ip4_rtl_rfm_wbq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .spa     (spa_if.slave),
        .rf_we   (rf_we),
        .rf_grp  (rf_grp),
        .rf_adr  (rf_adr),
        .rf_msk  (rf_msk),
        .rf_data (rf_data),
        .ovf_err (ovf_err)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard comparison.
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drivers.
    task automatic idle();
        spa_if.wb_en     = '0;
        spa_if.wb_bk     = '0;
        spa_if.wb_grp    = '0;
        spa_if.wb_adr    = '0;
        spa_if.wb_tid    = '0;
        spa_if.wb_msk    = '0;
        spa_if.wb_data   = '0;
        spa_if.flush_en  = 1'b0;
        spa_if.flush_tid = '0;
    endtask

    task automatic drive_fu(input int f, input int bk, input int grp, input int adr,
                            input int tid, input logic [NUM_SP-1:0] msk, input int base);
        spa_if.wb_en[f] = 1'b1;
        spa_if.wb_bk[f*BK_BITS +: BK_BITS]    = BK_BITS'(bk);
        spa_if.wb_grp[f*GRP_BITS +: GRP_BITS] = GRP_BITS'(grp);
        spa_if.wb_adr[f*ADR_BITS +: ADR_BITS] = ADR_BITS'(adr);
        spa_if.wb_tid[f*TID_BITS +: TID_BITS] = TID_BITS'(tid);
        spa_if.wb_msk[f*NUM_SP +: NUM_SP]     = msk;
        for (int l = 0; l < NUM_SP; l++) begin
            spa_if.wb_data[(f*NUM_SP+l)*WORD_BITS +: WORD_BITS] = WORD_BITS'(base + l);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] lanes(input int base);
        logic [LW-1:0] v;
        for (int l = 0; l < NUM_SP; l++) begin
            v[l*WORD_BITS +: WORD_BITS] = WORD_BITS'(base + l);
        end
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();

        // Reset state.
        chk("rst_we", rf_we, '0);
        chk("rst_grp", rf_grp, '0);
        chk("rst_adr", rf_adr, '0);
        chk("rst_msk", rf_msk, '0);
        for (int b = 0; b < NUM_BK; b++) chk("rst_data", rf_data[b*LW +: LW], '0);
        chk("rst_stall", spa_if.wb_stall, 1'b0);
        chk("rst_ovf", ovf_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single write: FU1 -> bank 2.
        drive_fu(1, 2, 1, 5, 0, 8'hFF, 0);
        tick();
        idle();
        tick();
        chk("single_we", rf_we, 4'b0100);
        chk("single_adr", rf_adr[2*ADR_BITS +: ADR_BITS], 6'd5);
        chk("single_grp", rf_grp[2*GRP_BITS +: GRP_BITS], 2'd1);
        chk("single_msk", rf_msk[2*NUM_SP +: NUM_SP], 8'hFF);
        chk("single_data", rf_data[2*LW +: LW], lanes(0));
        tick();
        chk("single_done_we", rf_we, '0);
        chk("single_hold_adr", rf_adr[2*ADR_BITS +: ADR_BITS], 6'd5);

        // Bank conflict: three FUs into bank 0 in one cycle drain in FU order.
        drive_fu(0, 0, 0, 1, 1, 8'hFF, 16);
        drive_fu(1, 0, 0, 2, 1, 8'hFF, 32);
        drive_fu(2, 0, 0, 3, 1, 8'hFF, 48);
        exp_q.push_back(6'd1);
        exp_q.push_back(6'd2);
        exp_q.push_back(6'd3);
        tick();
        idle();
        chk("conf_stall", spa_if.wb_stall, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("conf_we", rf_we, 4'b0001);
            chk("conf_adr", rf_adr[0 +: ADR_BITS], exp_q.pop_front());
            chk("conf_data", rf_data[0 +: LW], lanes(16 + 16*k));
            chk("conf_stall_drain", spa_if.wb_stall, 1'b0);
        end
        tick();
        chk("conf_done_we", rf_we, '0);

        // Backpressure on bank 3 and a request presented while stalled.
        for (int k = 0; k < 6; k++) exp_q.push_back(ADR_BITS'(10 + k));
        drive_fu(0, 3, 0, 10, 1, 8'hFF, 0);
        drive_fu(1, 3, 0, 11, 1, 8'hFF, 0);
        drive_fu(2, 3, 0, 12, 1, 8'hFF, 0);
        tick();
        chk("bp_stall_occ3", spa_if.wb_stall, 1'b0);
        drive_fu(0, 3, 0, 13, 1, 8'hFF, 0);
        drive_fu(1, 3, 0, 14, 1, 8'hFF, 0);
        drive_fu(2, 3, 0, 15, 1, 8'hFF, 0);
        tick();
        idle();
        chk("bp_stall_occ5", spa_if.wb_stall, 1'b1);
        chk("bp_ovf_clean", ovf_err, 1'b0);
        chk("bp_we0", rf_we, 4'b1000);
        chk("bp_adr0", rf_adr[3*ADR_BITS +: ADR_BITS], exp_q.pop_front());
        drive_fu(0, 1, 0, 60, 1, 8'hFF, 0);
        tick();
        idle();
        chk("bp_ovf_set", ovf_err, 1'b1);
        chk("bp_stall_occ4", spa_if.wb_stall, 1'b1);
        chk("bp_we1", rf_we, 4'b1000);
        chk("bp_adr1", rf_adr[3*ADR_BITS +: ADR_BITS], exp_q.pop_front());
        tick();
        chk("bp_stall_occ3_clear", spa_if.wb_stall, 1'b0);
        chk("bp_we2", rf_we, 4'b1000);
        chk("bp_adr2", rf_adr[3*ADR_BITS +: ADR_BITS], exp_q.pop_front());
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_we_tail", rf_we, 4'b1000);
            chk("bp_adr_tail", rf_adr[3*ADR_BITS +: ADR_BITS], exp_q.pop_front());
        end
        tick();
        chk("bp_done_we", rf_we, '0);
        chk("bp_ovf_sticky", ovf_err, 1'b1);

        // Flush tid 2 with tids 2,5,2 queued on bank 1.
        drive_fu(0, 1, 0, 20, 2, 8'hFF, 0);
        drive_fu(1, 1, 0, 21, 5, 8'hFF, 100);
        drive_fu(2, 1, 0, 22, 2, 8'hFF, 0);
        tick();
        idle();
        spa_if.flush_en  = 1'b1;
        spa_if.flush_tid = 3'd2;
        drive_fu(0, 2, 0, 30, 2, 8'hFF, 0);
        tick();
        idle();
        chk("fl_head_killed", rf_we, '0);
        tick();
        chk("fl_survivor_we", rf_we, 4'b0010);
        chk("fl_survivor_adr", rf_adr[1*ADR_BITS +: ADR_BITS], 6'd21);
        chk("fl_survivor_data", rf_data[1*LW +: LW], lanes(100));
        tick();
        chk("fl_cleared_slot", rf_we, '0);
        chk("fl_hold_adr", rf_adr[1*ADR_BITS +: ADR_BITS], 6'd21);
        tick();
        chk("fl_empty", rf_we, '0);

        // Zero mask is dropped; partial mask passes; idle-tid flush is harmless.
        drive_fu(0, 0, 0, 40, 3, 8'h00, 0);
        drive_fu(1, 1, 2, 41, 3, 8'h81, 200);
        spa_if.flush_en  = 1'b1;
        spa_if.flush_tid = 3'd6;
        tick();
        idle();
        tick();
        chk("msk_we", rf_we, 4'b0010);
        chk("msk_partial", rf_msk[1*NUM_SP +: NUM_SP], 8'h81);
        chk("msk_adr", rf_adr[1*ADR_BITS +: ADR_BITS], 6'd41);
        chk("msk_grp", rf_grp[1*GRP_BITS +: GRP_BITS], 2'd2);
        chk("msk_zero_hold", rf_adr[0 +: ADR_BITS], 6'd3);
        tick();
        chk("msk_done_we", rf_we, '0);

        // Reset with four entries queued.
        drive_fu(0, 2, 0, 50, 1, 8'hFF, 0);
        drive_fu(1, 2, 0, 51, 1, 8'hFF, 0);
        drive_fu(2, 2, 0, 52, 1, 8'hFF, 0);
        tick();
        idle();
        drive_fu(0, 0, 0, 53, 1, 8'hFF, 0);
        drive_fu(1, 2, 0, 54, 1, 8'hFF, 0);
        tick();
        idle();
        chk("mid_we", rf_we, 4'b0100);
        chk("mid_adr", rf_adr[2*ADR_BITS +: ADR_BITS], 6'd50);
        rst_n = 1'b0;
        tick();
        chk("mr_we", rf_we, '0);
        chk("mr_adr", rf_adr, '0);
        chk("mr_grp", rf_grp, '0);
        chk("mr_msk", rf_msk, '0);
        for (int b = 0; b < NUM_BK; b++) chk("mr_data", rf_data[b*LW +: LW], '0);
        chk("mr_stall", spa_if.wb_stall, 1'b0);
        chk("mr_ovf", ovf_err, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mr_no_stale", rf_we, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
